// File: rtl/rom_loader.sv
// Boot-time memory loader: receives a framed byte stream (length, payload, XOR checksum),
// assembles little-endian words and writes them to consecutive addresses while holding the core.
module rom_loader #(
  parameter int                DW        = 32,
  parameter int                AW        = 32,
  parameter logic [AW-1:0]     BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  output logic          rx_ready,
  output logic          wen,
  output logic [AW-1:0] w_addr,
  output logic [DW-1:0] w_data,
  output logic          core_hold,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state, state_next;
  logic [1:0]      byte_cnt;
  logic [31:0]     word_idx;
  logic [31:0]     len;
  logic [7:0]      csum;
  logic [DW-1:0]   word_reg;

  logic            accept;
  logic            last_byte;
  logic [31:0]     len_next;
  logic [DW-1:0]   word_next;
  logic [AW-1:0]   addr_next;

  assign accept    = rx_valid && rx_ready;
  assign last_byte = (byte_cnt == 2'd3);
  // Bytes arrive LSB first, so each new byte enters at the top and shifts the rest down.
  assign len_next  = {rx_data, len[31:8]};
  assign word_next = {rx_data, word_reg[DW-1:8]};
  assign addr_next = BASE_ADDR + AW'(word_idx << 2);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every output and next-state is given a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    wen        = 1'b0;
    busy       = 1'b0;
    core_hold  = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_next = S_LEN;
      end
      S_LEN: begin
        rx_ready  = 1'b1;
        busy      = 1'b1;
        core_hold = 1'b1;
        if (accept && last_byte) begin
          if (len_next > MAX_WORDS) state_next = S_ERR;
          else if (len_next == 32'd0) state_next = S_CSUM;
          else                        state_next = S_DATA;
        end
      end
      S_DATA: begin
        rx_ready  = 1'b1;
        busy      = 1'b1;
        core_hold = 1'b1;
        if (accept && last_byte) state_next = S_WRITE;
      end
      S_WRITE: begin
        wen       = 1'b1;
        busy      = 1'b1;
        core_hold = 1'b1;
        state_next = (word_idx + 32'd1 == len) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        rx_ready  = 1'b1;
        busy      = 1'b1;
        core_hold = 1'b1;
        if (accept) state_next = (rx_data == csum) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_next = S_LEN;
      end
      S_ERR: begin
        err       = 1'b1;
        core_hold = 1'b1;
        if (start) state_next = S_LEN;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt <= '0;
      word_idx <= '0;
      len      <= '0;
      csum     <= '0;
      word_reg <= '0;
      w_addr   <= '0;
      w_data   <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            byte_cnt <= '0;
            word_idx <= '0;
            len      <= '0;
            csum     <= '0;
          end
        end
        S_LEN: begin
          if (accept) begin
            len      <= len_next;
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_DATA: begin
          if (accept) begin
            word_reg <= word_next;
            csum     <= csum ^ rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            // Address and data are latched here so they are valid during WRITE and held afterwards.
            if (last_byte) begin
              w_data <= word_next;
              w_addr <= addr_next;
            end
          end
        end
        S_WRITE: word_idx <= word_idx + 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Directed self-checking bench for rom_loader: frame loads, gaps, empty frames,
// oversize length, checksum error recovery, start-while-busy and mid-frame reset.
module tb_rom_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        wen;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic        core_hold;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [63:0] wq[$];
  int          wen_ready_bad = 0;
  logic [7:0]  frame[$];

  rom_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .wen       (wen),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .core_hold (core_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled mid-cycle while state is stable.
  always @(negedge clk) begin
    if (wen) begin
      wq.push_back({w_addr, w_data});
      if (rx_ready) wen_ready_bad++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("byte_accept", {63'd0, rx_ready}, 64'd1);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input int gap);
    foreach (frame[i]) begin
      send_byte(frame[i]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic [3:0] exp_bhde);
    check(tag, {60'd0, busy, core_hold, done, err}, {60'd0, exp_bhde});
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_outputs", {rx_ready, wen, core_hold, busy, done, err, w_addr, w_data},
          {6'b0, 32'h0, 32'h0});
    rst = 1'b0;
    @(negedge clk);

    // N=2 back-to-back; XOR of payload bytes is 0x2A.
    wq.delete();
    do_start();
    check_status("start_busy", 4'b1100);
    frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
              8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
    send_frame(0);
    check("n2_count", wq.size(), 2);
    if (wq.size() == 2) begin
      check("n2_w0", wq[0], {32'h0, 32'h1234_5678});
      check("n2_w1", wq[1], {32'h4, 32'hDEAD_BEEF});
    end
    check_status("n2_done", 4'b0010);
    check("n2_hold_addr", {w_addr, w_data}, {32'h4, 32'hDEAD_BEEF});

    // Same frame with 3 idle cycles between bytes.
    wq.delete();
    wen_ready_bad = 0;
    do_start();
    check_status("restart_clears_done", 4'b1100);
    send_frame(3);
    check("gap_count", wq.size(), 2);
    if (wq.size() == 2) begin
      check("gap_w0", wq[0], {32'h0, 32'h1234_5678});
      check("gap_w1", wq[1], {32'h4, 32'hDEAD_BEEF});
    end
    check("gap_ready_in_write", wen_ready_bad, 0);
    check_status("gap_done", 4'b0010);

    // N=0, correct checksum.
    wq.delete();
    do_start();
    frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(0);
    check("n0_no_wen", wq.size(), 0);
    check_status("n0_done", 4'b0010);

    // N=0, bad checksum.
    do_start();
    frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    send_frame(0);
    check("n0bad_no_wen", wq.size(), 0);
    check_status("n0bad_err", 4'b0101);

    // N=4097 exceeds MAX_WORDS.
    do_start();
    frame = '{8'h01, 8'h10, 8'h00, 8'h00};
    send_frame(0);
    check_status("big_err", 4'b0101);
    check("big_ready", {63'd0, rx_ready}, 64'd0);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (6) @(negedge clk);
    rx_valid = 1'b0;
    check("big_no_wen", wq.size(), 0);
    check_status("big_err_sticky", 4'b0101);

    // N=1 with wrong checksum (correct is 0x00).
    do_start();
    frame = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h45};
    send_frame(0);
    check("csbad_count", wq.size(), 1);
    if (wq.size() == 1) check("csbad_w0", wq[0], {32'h0, 32'hDDCC_BBAA});
    check_status("csbad_err", 4'b0101);

    // Recovery: valid N=1 frame, checksum 11^22^33^44 = 0x44.
    wq.delete();
    do_start();
    check_status("recover_clears_err", 4'b1100);
    frame = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_frame(0);
    check("recover_count", wq.size(), 1);
    if (wq.size() == 1) check("recover_w0", wq[0], {32'h0, 32'h4433_2211});
    check_status("recover_done", 4'b0010);

    // Start pulse during DATA is ignored.
    wq.delete();
    do_start();
    frame = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
    send_frame(0);
    do_start();
    frame = '{8'h33, 8'h44, 8'h44};
    send_frame(0);
    check("busy_start_count", wq.size(), 1);
    if (wq.size() == 1) check("busy_start_w0", wq[0], {32'h0, 32'h4433_2211});
    check_status("busy_start_done", 4'b0010);

    // Reset mid-frame after one word written and two bytes of the next.
    wq.delete();
    do_start();
    frame = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE};
    send_frame(0);
    check("pre_rst_count", wq.size(), 1);
    check_status("pre_rst_busy", 4'b1100);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outputs", {rx_ready, wen, core_hold, busy, done, err, w_addr, w_data},
          {6'b0, 32'h0, 32'h0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_status("post_rst_idle", 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
